// File: rtl/memory_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access.
// Fixed data priority with a fetch anti-starvation counter and a lock for atomic sequences.
module memory_arbiter #(
  parameter int D_BURST = 4
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  output logic        i_abort,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_write,
  input  logic        d_size,
  input  logic        d_lock,
  input  logic        priv,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_abort,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic        write,
  output logic        size,
  output logic [1:0]  prot,
  output logic [1:0]  trans,
  input  logic [31:0] rdata,
  input  logic        abort
);

  localparam logic [1:0] OWN_NONE   = 2'd0;
  localparam logic [1:0] OWN_INSTR  = 2'd1;
  localparam logic [1:0] OWN_DATA   = 2'd2;
  localparam logic [1:0] OWN_LOCKED = 2'd3;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_FETCH = 2'd1;
  localparam logic [1:0] SRC_DATA  = 2'd2;

  localparam logic [3:0] BURST_MAX = 4'(D_BURST);

  logic [1:0]  r_own;
  logic [3:0]  r_starve;
  logic [1:0]  r_ap_src;
  logic [1:0]  r_dp_src;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_write;
  logic        r_size;
  logic [1:0]  r_prot;
  logic [1:0]  r_trans;

  logic        w_locked;
  logic        w_fetch_due;
  logic        w_d_win;
  logic        w_i_win;
  logic [1:0]  w_nxt_src;
  logic [31:0] w_nxt_addr;
  logic        w_seq;

  // Internal wins are ungated; only the visible grants are forced low during reset.
  assign w_locked    = (r_own == OWN_LOCKED);
  assign w_fetch_due = (r_starve == BURST_MAX);
  assign w_d_win     = d_req & (w_locked | ~i_req | ~w_fetch_due);
  assign w_i_win     = i_req & ~w_locked & (~d_req | w_fetch_due);

  assign w_nxt_src  = w_d_win ? SRC_DATA : (w_i_win ? SRC_FETCH : SRC_NONE);
  assign w_nxt_addr = w_d_win ? d_addr : i_addr;
  assign w_seq      = (w_nxt_src == r_ap_src) && (w_nxt_addr == (r_addr + 32'd1));

  assign d_gnt = w_d_win & n_reset;
  assign i_gnt = w_i_win & n_reset;

  assign addr  = r_addr;
  assign wdata = r_wdata;
  assign write = r_write;
  assign size  = r_size;
  assign prot  = r_prot;
  assign trans = r_trans;

  assign i_valid = (r_dp_src == SRC_FETCH);
  assign d_valid = (r_dp_src == SRC_DATA);
  assign i_abort = i_valid & abort;
  assign d_abort = d_valid & abort;
  assign i_rdata = rdata;
  assign d_rdata = rdata;

  // Address-phase bus registers, loaded on every grant.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_write <= 1'b0;
      r_size  <= 1'b0;
      r_prot  <= 2'b00;
      r_trans <= 2'b00;
    end else if (w_d_win || w_i_win) begin
      r_addr  <= w_nxt_addr;
      r_wdata <= w_d_win ? d_wdata : 32'd0;
      r_write <= w_d_win & d_write;
      r_size  <= w_d_win ? d_size : 1'b1;
      r_prot  <= {priv, w_d_win};
      r_trans <= w_seq ? 2'b11 : 2'b10;
    end else begin
      r_trans <= 2'b00;
    end
  end

  // Ownership state; a lock survives idle cycles until an unlocked data grant.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_own <= OWN_NONE;
    end else if (w_d_win) begin
      r_own <= d_lock ? OWN_LOCKED : OWN_DATA;
    end else if (w_i_win) begin
      r_own <= OWN_INSTR;
    end else if (w_locked) begin
      r_own <= OWN_LOCKED;
    end else begin
      r_own <= OWN_NONE;
    end
  end

  // Counts data grants that passed over a waiting fetch, saturating at the burst limit.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_starve <= 4'd0;
    end else if (w_d_win && i_req) begin
      r_starve <= w_fetch_due ? r_starve : (r_starve + 4'd1);
    end else if (w_i_win || !i_req) begin
      r_starve <= 4'd0;
    end else begin
      r_starve <= r_starve;
    end
  end

  // Pipeline of requester identities: address phase, then data phase.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_ap_src <= SRC_NONE;
      r_dp_src <= SRC_NONE;
    end else begin
      r_ap_src <= w_nxt_src;
      r_dp_src <= r_ap_src;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a rule-level arbitration model queues expected
// address and data phases; a negedge monitor plays the memory and checks the DUT.
module tb_memory_arbiter;
  localparam int D_BURST = 4;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        i_req, d_req, d_write, d_size, d_lock, priv;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_valid, i_abort, d_gnt, d_valid, d_abort;
  logic [31:0] i_rdata, d_rdata, addr, wdata, rdata;
  logic        write, size, abort;
  logic [1:0]  prot, trans;

  memory_arbiter #(.D_BURST(D_BURST)) dut (
    .clk(clk), .n_reset(n_reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid),
    .i_rdata(i_rdata), .i_abort(i_abort),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_write(d_write),
    .d_size(d_size), .d_lock(d_lock), .priv(priv), .d_gnt(d_gnt),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_abort(d_abort),
    .addr(addr), .wdata(wdata), .write(write), .size(size), .prot(prot),
    .trans(trans), .rdata(rdata), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          src;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        sz;
    logic [1:0]  prot;
    logic [1:0]  trans;
  } ap_t;

  typedef struct {
    int          due;
    int          src;
    logic [31:0] rdata;
    logic        ab;
  } dp_t;

  ap_t ap_q[$];
  dp_t dp_q[$];
  int  gseq[$];

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          m_wait = 0;
  bit          m_lock = 1'b0;
  int          m_prev_src = 0;
  logic [31:0] m_prev_addr = 32'd0;
  bit          g_i = 1'b0, g_d = 1'b0;
  int          dabort_cnt = 0;
  bit          force_abort = 1'b0;
  bit          rand_abort = 1'b0;

  ap_t         a_exp, a_new;
  dp_t         d_exp, d_new;
  bit          eg_i, eg_d, ab_now;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0000A5A5;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory model, monitor and arbitration reference model, all at the falling edge.
  always @(negedge clk) begin
    if (!n_reset) begin
      ap_q.delete();
      dp_q.delete();
      m_wait = 0;
      m_lock = 1'b0;
      m_prev_src = 0;
      m_prev_addr = 32'd0;
      g_i = 1'b0;
      g_d = 1'b0;
      abort = 1'b0;
    end else begin
      if (dp_q.size() > 0 && dp_q[0].due == cyc) begin
        d_exp = dp_q.pop_front();
        chk("i_valid", i_valid, d_exp.src == 1);
        chk("d_valid", d_valid, d_exp.src == 2);
        if (d_exp.src == 1) begin
          chk("i_rdata", i_rdata, d_exp.rdata);
          chk("i_abort", i_abort, d_exp.ab);
          chk("d_abort_other", d_abort, 0);
        end else begin
          chk("d_rdata", d_rdata, d_exp.rdata);
          chk("d_abort", d_abort, d_exp.ab);
          chk("i_abort_other", i_abort, 0);
        end
      end else begin
        chk("i_valid_idle", i_valid, 0);
        chk("d_valid_idle", d_valid, 0);
      end
      if (d_valid && d_abort) dabort_cnt++;

      if (ap_q.size() > 0 && ap_q[0].due == cyc) begin
        a_exp = ap_q.pop_front();
        chk("trans", trans, a_exp.trans);
        chk("addr", addr, a_exp.addr);
        chk("wdata", wdata, a_exp.wdata);
        chk("write", write, a_exp.wr);
        chk("size", size, a_exp.sz);
        chk("prot", prot, a_exp.prot);
        ab_now = (force_abort && a_exp.src == 2 && a_exp.addr == 32'h20) ||
                 (rand_abort && $urandom_range(0, 7) == 0);
        abort = ab_now;
        rdata = memf(addr);
        d_new.due = cyc + 1;
        d_new.src = a_exp.src;
        d_new.rdata = memf(a_exp.addr);
        d_new.ab = ab_now;
        dp_q.push_back(d_new);
      end else begin
        chk("trans_idle", trans, 2'b00);
        chk("addr_hold", addr, m_prev_addr);
        abort = 1'b0;
        rdata = $urandom;
      end

      if (m_lock) begin
        eg_d = d_req;
        eg_i = 1'b0;
      end else if (i_req && d_req) begin
        eg_i = (m_wait == D_BURST);
        eg_d = !eg_i;
      end else begin
        eg_i = i_req;
        eg_d = d_req;
      end
      chk("d_gnt", d_gnt, eg_d);
      chk("i_gnt", i_gnt, eg_i);

      if (eg_d || eg_i) begin
        a_new.due = cyc + 1;
        a_new.src = eg_d ? 2 : 1;
        a_new.addr = eg_d ? d_addr : i_addr;
        a_new.wdata = eg_d ? d_wdata : 32'd0;
        a_new.wr = eg_d && d_write;
        a_new.sz = eg_d ? d_size : 1'b1;
        a_new.prot = {priv, eg_d};
        a_new.trans = (a_new.src == m_prev_src && a_new.addr == m_prev_addr + 32'd1) ? 2'b11 : 2'b10;
        ap_q.push_back(a_new);
        gseq.push_back(a_new.src);
        m_prev_addr = a_new.addr;
      end
      m_prev_src = eg_d ? 2 : (eg_i ? 1 : 0);
      if (eg_d && i_req) m_wait = (m_wait < D_BURST) ? m_wait + 1 : D_BURST;
      else if (eg_i || !i_req) m_wait = 0;
      if (eg_d) m_lock = d_lock;
      g_i = eg_i;
      g_d = eg_d;
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    n_reset = 1'b0;
    #1;
    chk("rst_trans", trans, 2'b00);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_i_valid", i_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_addr", addr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;
  endtask

  task automatic wait_d();
    int n = 0;
    do begin step(); n++; end while (!g_d && n < 20);
    chk("d_grant_wait", g_d, 1);
  endtask

  task automatic wait_i();
    int n = 0;
    do begin step(); n++; end while (!g_i && n < 20);
    chk("i_grant_wait", g_i, 1);
  endtask

  task automatic check_pattern(input int base);
    chk("gseq_len", gseq.size() >= base + 10, 1);
    for (int k = 0; k < 10; k++) begin
      if (base + k < gseq.size())
        chk("gseq", gseq[base + k], ((k % (D_BURST + 1)) == D_BURST) ? 1 : 2);
    end
  endtask

  initial begin
    logic [31:0] fa [5];
    int base;
    int n;
    n_reset = 1'b1;
    i_req = 1'b1; d_req = 1'b1;
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
    d_write = 1'b0; d_size = 1'b0; d_lock = 1'b0; priv = 1'b0;
    #2;
    n_reset = 1'b0;
    #1;
    chk("rst0_trans", trans, 2'b00);
    chk("rst0_gnt", {i_gnt, d_gnt}, 2'b00);
    chk("rst0_valid", {i_valid, d_valid}, 2'b00);
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;
    repeat (3) step();

    // Fetch-only stream including the address wrap.
    fa[0] = 32'd0; fa[1] = 32'd1; fa[2] = 32'd2; fa[3] = 32'hFFFF_FFFF; fa[4] = 32'd0;
    i_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_addr = fa[k];
      wait_i();
    end
    i_req = 1'b0;
    repeat (4) step();

    // Both requesting continuously, then a reset pulse during a data phase.
    apply_reset();
    base = gseq.size();
    i_addr = 32'h40; d_addr = 32'h80; d_write = 1'b0; d_lock = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    repeat (10) step();
    check_pattern(base);
    n = 0;
    do begin @(negedge clk); n++; end while (!d_valid && n < 10);
    chk("dvalid_before_reset", d_valid, 1);
    #1;
    apply_reset();
    base = gseq.size();
    repeat (10) step();
    check_pattern(base);
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) step();

    // Locked read-modify-write with fetch waiting.
    apply_reset();
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_addr = 32'h10; d_write = 1'b0; d_lock = 1'b1;
    wait_d();
    d_write = 1'b1; d_wdata = 32'hCAFE_F00D; d_lock = 1'b0;
    wait_d();
    d_req = 1'b0; d_write = 1'b0;
    step();
    chk("lock_release_i_gnt", g_i, 1);
    i_req = 1'b0;
    repeat (4) step();

    // Abort routed to the data requester only.
    apply_reset();
    force_abort = 1'b1;
    base = dabort_cnt;
    d_req = 1'b1; d_addr = 32'h20; d_write = 1'b0; d_lock = 1'b0;
    wait_d();
    d_req = 1'b0;
    repeat (3) step();
    chk("d_abort_seen", dabort_cnt - base, 1);
    force_abort = 1'b0;

    // Randomized traffic.
    apply_reset();
    rand_abort = 1'b1;
    for (int c = 0; c < 400; c++) begin
      step();
      priv = 1'($urandom_range(0, 1));
      if (!i_req || g_i) begin
        i_req = ($urandom_range(0, 2) != 0);
        i_addr = ($urandom_range(0, 2) == 0) ? $urandom : i_addr + 32'd1;
      end
      if (!d_req || g_d) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_addr = ($urandom_range(0, 2) == 0) ? $urandom : d_addr + 32'd1;
        d_write = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
        d_size = 1'($urandom_range(0, 1));
        d_lock = ($urandom_range(0, 5) == 0);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

endmodule
